branch_history_table: RTL and testbench



---
 rtl/sail_bht_pkg.sv | 16 +
 rtl/bht_counter_table.sv | 49 ++++
 rtl/branch_history_table.sv | 112 +++++++++++
 tb/tb_branch_history_table.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sail_bht_pkg.sv
// Shared definitions for the sail branch history table: 2-bit counter
// encodings, the counter reset value and the sequential PC step.
package sail_bht_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam logic [1:0] CTR_RESET = WNT;

    localparam int unsigned SEQ_PC_STEP = 4;

endpackage

// File: rtl/bht_counter_table.sv
// Array of 2-bit saturating counters with one asynchronous read port
// (taken bit only) and one write port that performs the saturating
// read-modify-write internally. Small enough to map onto flops/LUT-RAM.
module bht_counter_table
    import sail_bht_pkg::*;
#(
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_taken,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic                  wr_taken
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    logic [1:0] table_q [ENTRIES];

    // Saturating step of a 2-bit counter toward the resolved direction.
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != ST) nxt = ctr + 2'd1;
        end else begin
            if (ctr != SNT) nxt = ctr - 2'd1;
        end
        return nxt;
    endfunction

    // Counter storage: reset to weakly-not-taken, otherwise train on write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= CTR_RESET;
            end
        end else if (wr_en) begin
            table_q[wr_idx] <= sat_update(table_q[wr_idx], wr_taken);
        end
    end

    // Prediction is the counter MSB; reading before the edge gives the
    // pre-update value when read and write hit the same entry.
    assign rd_taken = table_q[rd_idx][1];

endmodule

// File: rtl/branch_history_table.sv
// Dynamic conditional-branch predictor for the sail core. Serves registered
// predictions/targets to fetch/decode, trains 2-bit counters from the ALU's
// resolved branch outcome and raises a registered mispredict with the
// recovery PC. Optional perf counters: define BHT_PERF_COUNTERS_EN.
module branch_history_table
    import sail_bht_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lookup_valid,
    input  logic [ADDR_WIDTH-1:0] lookup_pc,
    input  logic [ADDR_WIDTH-1:0] lookup_offset,
    input  logic                  flush,
    output logic                  predict_valid,
    output logic                  predict_taken,
    output logic [ADDR_WIDTH-1:0] predict_target,
    input  logic                  resolve_valid,
    input  logic [ADDR_WIDTH-1:0] resolve_pc,
    input  logic [ADDR_WIDTH-1:0] resolve_offset,
    input  logic                  resolve_taken,
    input  logic                  resolve_predicted,
    output logic                  mispredict,
    output logic [ADDR_WIDTH-1:0] correct_pc
`ifdef BHT_PERF_COUNTERS_EN
    ,
    output logic [31:0]           branch_count,
    output logic [31:0]           mispredict_count
`endif
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(SEQ_PC_STEP);

    logic                  lookup_taken_p0;
    logic                  lookup_fire_p0;
    logic [ADDR_WIDTH-1:0] lookup_target_p0;
    logic                  mispredict_p0;
    logic [ADDR_WIDTH-1:0] correct_pc_p0;

    logic                  vld_p1;
    logic                  pred_taken_p1;
    logic [ADDR_WIDTH-1:0] pred_target_p1;
    logic                  mispredict_p1;
    logic [ADDR_WIDTH-1:0] correct_pc_p1;

    bht_counter_table #(
        .INDEX_BITS (INDEX_BITS)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (lookup_pc[INDEX_BITS+1:2]),
        .rd_taken (lookup_taken_p0),
        .wr_en    (resolve_valid),
        .wr_idx   (resolve_pc[INDEX_BITS+1:2]),
        .wr_taken (resolve_taken)
    );

    // ---- stage p0: combinational lookup/resolve, modulo-2^ADDR_WIDTH adds ----
    always_comb begin
        lookup_fire_p0   = lookup_valid & ~flush;
        lookup_target_p0 = lookup_taken_p0 ? (lookup_pc + lookup_offset)
                                           : (lookup_pc + PC_STEP);
        mispredict_p0    = resolve_valid & (resolve_taken ^ resolve_predicted);
        correct_pc_p0    = resolve_taken ? (resolve_pc + resolve_offset)
                                         : (resolve_pc + PC_STEP);
    end

    // ---- stage p1: output registers, single-cycle pulses, zero when idle ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1         <= 1'b0;
            pred_taken_p1  <= 1'b0;
            pred_target_p1 <= '0;
            mispredict_p1  <= 1'b0;
            correct_pc_p1  <= '0;
        end else begin
            vld_p1         <= lookup_fire_p0;
            pred_taken_p1  <= lookup_fire_p0 & lookup_taken_p0;
            pred_target_p1 <= lookup_fire_p0 ? lookup_target_p0 : '0;
            mispredict_p1  <= mispredict_p0;
            correct_pc_p1  <= mispredict_p0 ? correct_pc_p0 : '0;
        end
    end

    assign predict_valid  = vld_p1;
    assign predict_taken  = pred_taken_p1;
    assign predict_target = pred_target_p1;
    assign mispredict     = mispredict_p1;
    assign correct_pc     = correct_pc_p1;

`ifdef BHT_PERF_COUNTERS_EN
    logic [31:0] branch_cnt_p1;
    logic [31:0] mispredict_cnt_p1;

    // Resolve and mispredict counters, updated on the same edge as the table.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_cnt_p1     <= '0;
            mispredict_cnt_p1 <= '0;
        end else begin
            if (resolve_valid) branch_cnt_p1     <= branch_cnt_p1 + 32'd1;
            if (mispredict_p0) mispredict_cnt_p1 <= mispredict_cnt_p1 + 32'd1;
        end
    end

    assign branch_count     = branch_cnt_p1;
    assign mispredict_count = mispredict_cnt_p1;
`endif

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench for branch_history_table with hand-computed expectations.
module tb_branch_history_table;

    logic        clk = 1'b0;
    logic        reset;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic [31:0] lookup_offset;
    logic        flush;
    logic        predict_valid;
    logic        predict_taken;
    logic [31:0] predict_target;
    logic        resolve_valid;
    logic [31:0] resolve_pc;
    logic [31:0] resolve_offset;
    logic        resolve_taken;
    logic        resolve_predicted;
    logic        mispredict;
    logic [31:0] correct_pc;
`ifdef BHT_PERF_COUNTERS_EN
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_history_table #(
        .INDEX_BITS (4),
        .ADDR_WIDTH (32)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .lookup_valid      (lookup_valid),
        .lookup_pc         (lookup_pc),
        .lookup_offset     (lookup_offset),
        .flush             (flush),
        .predict_valid     (predict_valid),
        .predict_taken     (predict_taken),
        .predict_target    (predict_target),
        .resolve_valid     (resolve_valid),
        .resolve_pc        (resolve_pc),
        .resolve_offset    (resolve_offset),
        .resolve_taken     (resolve_taken),
        .resolve_predicted (resolve_predicted),
        .mispredict        (mispredict),
        .correct_pc        (correct_pc)
`ifdef BHT_PERF_COUNTERS_EN
        ,
        .branch_count      (branch_count),
        .mispredict_count  (mispredict_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lookup_valid      = 1'b0;
        lookup_pc         = '0;
        lookup_offset     = '0;
        flush             = 1'b0;
        resolve_valid     = 1'b0;
        resolve_pc        = '0;
        resolve_offset    = '0;
        resolve_taken     = 1'b0;
        resolve_predicted = 1'b0;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic [31:0] off);
        lookup_valid  = 1'b1;
        lookup_pc     = pc;
        lookup_offset = off;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] off,
                           input logic taken, input logic pred);
        resolve_valid     = 1'b1;
        resolve_pc        = pc;
        resolve_offset    = off;
        resolve_taken     = taken;
        resolve_predicted = pred;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step();
        step();
        chk("rst_pvalid", 32'(predict_valid), 32'd0);
        chk("rst_ptaken", 32'(predict_taken), 32'd0);
        chk("rst_ptarget", predict_target, 32'h0);
        chk("rst_mispred", 32'(mispredict), 32'd0);
        chk("rst_cpc", correct_pc, 32'h0);
        reset = 1'b0;

        // First lookup from reset: WNT predicts not-taken, sequential target
        lookup(32'h100, 32'h40);
        step();
        chk("lk0_pvalid", 32'(predict_valid), 32'd1);
        chk("lk0_ptaken", 32'(predict_taken), 32'd0);
        chk("lk0_ptarget", predict_target, 32'h104);
        idle();
        step();
        chk("lk0_hold_pvalid", 32'(predict_valid), 32'd0);
        chk("lk0_hold_ptarget", predict_target, 32'h0);

        // Two taken resolves: 01 -> 10 -> 11
        resolve(32'h100, 32'h40, 1'b1, 1'b0);
        step();
        chk("tr1_mispred", 32'(mispredict), 32'd1);
        chk("tr1_cpc", correct_pc, 32'h140);
        resolve(32'h100, 32'h40, 1'b1, 1'b1);
        step();
        chk("tr2_mispred", 32'(mispredict), 32'd0);
        idle();
        lookup(32'h100, 32'h40);
        step();
        chk("lk1_ptaken", 32'(predict_taken), 32'd1);
        chk("lk1_ptarget", predict_target, 32'h140);

        // Five more taken stay at 11, one not-taken drops to 10
        idle();
        for (int i = 0; i < 5; i++) begin
            resolve(32'h100, 32'h40, 1'b1, 1'b1);
            step();
        end
        resolve(32'h100, 32'h40, 1'b0, 1'b1);
        step();
        chk("nt_mispred", 32'(mispredict), 32'd1);
        chk("nt_cpc", correct_pc, 32'h104);
        idle();
        lookup(32'h100, 32'h40);
        step();
        chk("sat_ptaken", 32'(predict_taken), 32'd1);
        chk("sat_ptarget", predict_target, 32'h140);

        // Negative offset, carry dropped
        idle();
        resolve(32'h200, 32'hFFFF_FFF0, 1'b1, 1'b0);
        step();
        chk("neg_mispred", 32'(mispredict), 32'd1);
        chk("neg_cpc", correct_pc, 32'h1F0);
        idle();
        step();
        chk("pulse_mispred", 32'(mispredict), 32'd0);
        resolve(32'h200, 32'hFFFF_FFF0, 1'b0, 1'b1);
        step();
        chk("nt2_mispred", 32'(mispredict), 32'd1);
        chk("nt2_cpc", correct_pc, 32'h204);

        // Same-cycle lookup and resolve on one index: lookup sees old counter
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        lookup(32'h300, 32'h20);
        resolve(32'h300, 32'h20, 1'b1, 1'b0);
        step();
        chk("same_pvalid", 32'(predict_valid), 32'd1);
        chk("same_ptaken", 32'(predict_taken), 32'd0);
        chk("same_ptarget", predict_target, 32'h304);
        chk("same_mispred", 32'(mispredict), 32'd1);
        chk("same_cpc", correct_pc, 32'h320);
        idle();
        lookup(32'h300, 32'h20);
        step();
        chk("after_ptaken", 32'(predict_taken), 32'd1);
        chk("after_ptarget", predict_target, 32'h320);

        // Flush beats lookup; table untouched
        lookup(32'h300, 32'h20);
        flush = 1'b1;
        step();
        chk("flush_pvalid", 32'(predict_valid), 32'd0);
        chk("flush_ptaken", 32'(predict_taken), 32'd0);
        flush = 1'b0;
        step();
        chk("postflush_pvalid", 32'(predict_valid), 32'd1);
        chk("postflush_ptaken", 32'(predict_taken), 32'd1);

        // Reset during a mispredicting resolve
        idle();
        reset = 1'b1;
        resolve(32'h300, 32'h20, 1'b1, 1'b0);
        step();
        chk("rstres_mispred", 32'(mispredict), 32'd0);
        chk("rstres_cpc", correct_pc, 32'h0);
        reset = 1'b0;
        idle();
        step();
        chk("rstres2_mispred", 32'(mispredict), 32'd0);
        lookup(32'h300, 32'h20);
        step();
        chk("rstres_ptaken", 32'(predict_taken), 32'd0);
        chk("rstres_ptarget", predict_target, 32'h304);
        idle();
        resolve(32'h300, 32'h20, 1'b1, 1'b0);
        step();
        idle();
        lookup(32'h300, 32'h20);
        step();
        chk("wnt_ptaken", 32'(predict_taken), 32'd1);

`ifdef BHT_PERF_COUNTERS_EN
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("perf_rst_bc", branch_count, 32'd0);
        chk("perf_rst_mc", mispredict_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            logic tk;
            tk = i[0];
            resolve(32'h400 + 32'(4 * i), 32'h8, tk,
                    (i == 2 || i == 5 || i == 8) ? ~tk : tk);
            step();
        end
        idle();
        chk("perf_bc", branch_count, 32'd10);
        chk("perf_mc", mispredict_count, 32'd3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
